// File: rtl/hynoc_ingress_mcast_ctrl_pkg.sv
// rtl/hynoc_ingress_mcast_ctrl_pkg.sv - shared constants and helpers for the ingress multicast sequencer
// Purpose: FSM state encoding, tail-bit position helper and counter-width helper.
// Ports: none (package).
package hynoc_ingress_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_REQ   = 3'd1;
  localparam logic [STATE_W-1:0] ST_XFER  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DROP  = 3'd3;
  localparam logic [STATE_W-1:0] ST_RETRY = 3'd4;

  // The tail marker is the most significant flit bit.
  function automatic int tail_bit(input int flit_width);
    return flit_width - 1;
  endfunction

  // Bits needed to count 0 .. value-1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/hynoc_ingress_mcast_ctrl_if.sv
// rtl/hynoc_ingress_mcast_ctrl_if.sv - ingress FIFO / route decode / egress crossbar bundle
// Purpose: groups every signal between the sequencer and its surroundings.
// Modports: master = the sequencer (drives fifo_read, to_egress_*, busy);
//           slave  = FIFO, route decoder and egress side.
interface hynoc_ingress_mcast_ctrl_if #(
  parameter int NB_PORTS   = 5,
  parameter int FLIT_WIDTH = 33
);
  logic [FLIT_WIDTH-1:0] fifo_rdata;
  logic                  fifo_empty;
  logic                  fifo_read;
  logic [NB_PORTS-2:0]   route_request;
  logic                  route_new_header_write;
  logic [FLIT_WIDTH-1:0] route_new_header;
  logic [NB_PORTS-2:0]   to_egress_request;
  logic [NB_PORTS-2:0]   from_egress_grant;
  logic [NB_PORTS-2:0]   from_egress_ready;
  logic                  to_egress_write;
  logic [FLIT_WIDTH-1:0] to_egress_data;
  logic                  busy;

  modport master (
    input  fifo_rdata, fifo_empty, route_request, route_new_header_write,
           route_new_header, from_egress_grant, from_egress_ready,
    output fifo_read, to_egress_request, to_egress_write, to_egress_data, busy
  );

  modport slave (
    output fifo_rdata, fifo_empty, route_request, route_new_header_write,
           route_new_header, from_egress_grant, from_egress_ready,
    input  fifo_read, to_egress_request, to_egress_write, to_egress_data, busy
  );
endinterface

// File: rtl/hynoc_ingress_mcast_ctrl_grant_timer.sv
// rtl/hynoc_ingress_mcast_ctrl_grant_timer.sv - grant-wait counter used by the timeout build
// Purpose: counts REQ cycles without full grant; exists only when
//          HYNOC_INGRESS_MCAST_TIMEOUT_EN is defined.
// Ports: clk_i, rst_ni (async active-low), clear_i (priority), enable_i, expire_o.
`ifdef HYNOC_INGRESS_MCAST_TIMEOUT_EN
module hynoc_mcast_grant_timer
  import hynoc_ingress_pkg::*;
#(
  parameter int CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  localparam int CW = clog2(CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == CW'(CYCLES - 1));
endmodule
`endif

// File: rtl/hynoc_ingress_mcast_ctrl.sv
// rtl/hynoc_ingress_mcast_ctrl.sv - per-ingress multicast packet sequencer
// Purpose: latches the egress mask of a head flit, requests all targeted
//          egresses, streams the packet once all are granted (substituting the
//          decremented header) and drains packets with an empty mask.
// Ports: router_clk, router_arst_n (async active-low), bus (master modport of
//        hynoc_ingress_mcast_ctrl_if).
// Option: HYNOC_INGRESS_MCAST_TIMEOUT_EN adds a grant-wait timeout with a
//         one-cycle request release (RETRY).
module hynoc_ingress_mcast_ctrl
  import hynoc_ingress_pkg::*;
#(
  parameter int NB_PORTS       = 5,
  parameter int INDEX_WIDTH    = 4,
  parameter int PAYLOAD_WIDTH  = 32,
  parameter int FLIT_WIDTH     = PAYLOAD_WIDTH + 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                         router_clk,
  input logic                         router_arst_n,
  hynoc_ingress_mcast_ctrl_if.master  bus
);
  localparam int MW   = NB_PORTS - 1;
  localparam int TAIL = tail_bit(FLIT_WIDTH);

  generate
    if (INDEX_WIDTH < 1 || INDEX_WIDTH > PAYLOAD_WIDTH ||
        FLIT_WIDTH != PAYLOAD_WIDTH + 1 || NB_PORTS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("hynoc_ingress_mcast_ctrl: invalid parameter set");
    end
  endgenerate

  logic [STATE_W-1:0]    state_q, state_d;
  logic [MW-1:0]         mask_q, mask_d;
  logic [MW-1:0]         req_q, req_d;
  logic                  first_q, first_d;
  logic                  busy_q;

  logic                  all_granted, all_ready, tail, xfer;
  logic                  fifo_read;
  logic                  egress_write;
  logic [FLIT_WIDTH-1:0] egress_data;

  assign all_granted = ((bus.from_egress_grant & mask_q) == mask_q);
  // Unmasked egresses never hold back a transfer.
  assign all_ready   = &(bus.from_egress_ready | ~mask_q);
  assign tail        = bus.fifo_rdata[TAIL];
  assign xfer        = (state_q == ST_XFER) && !bus.fifo_empty && all_granted && all_ready;

`ifdef HYNOC_INGRESS_MCAST_TIMEOUT_EN
  logic tmo_expire;

  hynoc_mcast_grant_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_grant_timer (
    .clk_i    (router_clk),
    .rst_ni   (router_arst_n),
    .clear_i  ((state_d == ST_REQ) && (state_q != ST_REQ)),
    .enable_i ((state_q == ST_REQ) && !all_granted),
    .expire_o (tmo_expire)
  );
`endif

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    req_d        = req_q;
    first_d      = first_q;
    fifo_read    = 1'b0;
    egress_write = 1'b0;
    egress_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.fifo_empty) begin
          mask_d  = bus.route_request;
          first_d = 1'b1;
          if (|bus.route_request) begin
            state_d = ST_REQ;
            req_d   = bus.route_request;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_REQ: begin
        if (all_granted) begin
          state_d = ST_XFER;
        end
`ifdef HYNOC_INGRESS_MCAST_TIMEOUT_EN
        else if (tmo_expire) begin
          // Release every request for one cycle to break partial-grant deadlock.
          state_d = ST_RETRY;
          req_d   = '0;
        end
`endif
      end
`ifdef HYNOC_INGRESS_MCAST_TIMEOUT_EN
      ST_RETRY: begin
        state_d = ST_REQ;
        req_d   = mask_q;
      end
`endif
      ST_XFER: begin
        egress_data = bus.fifo_rdata;
        if (xfer) begin
          fifo_read = 1'b1;
          first_d   = 1'b0;
          if (first_q) begin
            // Index-zero header is consumed here and not forwarded.
            if (bus.route_new_header_write) begin
              egress_write = 1'b1;
              egress_data  = bus.route_new_header;
            end
          end else begin
            egress_write = 1'b1;
          end
          if (tail) begin
            state_d = ST_IDLE;
            mask_d  = '0;
            req_d   = '0;
          end
        end
      end
      ST_DROP: begin
        egress_data = bus.fifo_rdata;
        if (!bus.fifo_empty) begin
          fifo_read = 1'b1;
          first_d   = 1'b0;
          if (tail) begin
            state_d = ST_IDLE;
            mask_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        mask_d  = '0;
        req_d   = '0;
      end
    endcase
  end

  always_ff @(posedge router_clk or negedge router_arst_n) begin
    if (!router_arst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      req_q   <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      req_q   <= req_d;
      first_q <= first_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.fifo_read         = fifo_read;
  assign bus.to_egress_request = req_q;
  assign bus.to_egress_write   = egress_write;
  assign bus.to_egress_data    = egress_data;
  assign bus.busy              = busy_q;
endmodule

// File: tb/tb_hynoc_ingress_mcast_ctrl.sv
// tb/tb_hynoc_ingress_mcast_ctrl.sv - self-checking bench for hynoc_ingress_mcast_ctrl
// Header flit layout used here: [3:0] hop index, [7:4] egress mask, [31:8] tag, [32] tail.
module tb_hynoc_ingress_mcast_ctrl;
  localparam int NB_PORTS      = 5;
  localparam int INDEX_WIDTH   = 4;
  localparam int PAYLOAD_WIDTH = 32;
  localparam int FLIT_WIDTH    = 33;
  localparam int TIMEOUT       = 8;
  localparam int MW            = NB_PORTS - 1;

  logic router_clk = 1'b0;
  logic router_arst_n = 1'b0;
  always #5 router_clk = ~router_clk;

  hynoc_ingress_mcast_ctrl_if #(.NB_PORTS(NB_PORTS), .FLIT_WIDTH(FLIT_WIDTH)) bus ();

  hynoc_ingress_mcast_ctrl #(
    .NB_PORTS       (NB_PORTS),
    .INDEX_WIDTH    (INDEX_WIDTH),
    .PAYLOAD_WIDTH  (PAYLOAD_WIDTH),
    .FLIT_WIDTH     (FLIT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .router_clk    (router_clk),
    .router_arst_n (router_arst_n),
    .bus           (bus)
  );

  typedef struct {
    logic [3:0] mask;
    logic [3:0] idx;
    int         nflits;
    int         exp_writes;
    int         exp_pops;
    bit         exp_req;
  } vec_t;

  logic [FLIT_WIDTH-1:0] fifo_q[$];
  logic [FLIT_WIDTH-1:0] exp_q[$];
  logic [MW-1:0]         req_log[$];
  bit                    wr_log[$];
  bit                    rd_log[$];
  bit                    busy_log[$];
  logic [MW-1:0]         grant_allow;
  logic [MW-1:0]         ready_drv;
  int                    vec_cnt, miss_cnt, wr_cnt, rd_cnt;
  bit                    req_seen, pop_pend;
  vec_t                  vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    logic [FLIT_WIDTH-1:0] h;
    if (fifo_q.size() == 0) begin
      bus.fifo_empty = 1'b1;
      h = '0;
    end else begin
      bus.fifo_empty = 1'b0;
      h = fifo_q[0];
    end
    bus.fifo_rdata             = h;
    bus.route_request          = h[7:4];
    bus.route_new_header_write = (h[3:0] != 4'd0);
    bus.route_new_header       = {h[FLIT_WIDTH-1:4], h[3:0] - 4'd1};
    bus.from_egress_grant      = bus.to_egress_request & grant_allow;
    bus.from_egress_ready      = ready_drv;
  endtask

  // One clock: observe at the falling edge, apply the pop just after the rising edge.
  task automatic cycle();
    drive_inputs();
    @(negedge router_clk);
    pop_pend = bus.fifo_read;
    req_log.push_back(bus.to_egress_request);
    wr_log.push_back(bus.to_egress_write);
    rd_log.push_back(bus.fifo_read);
    busy_log.push_back(bus.busy);
    if (bus.to_egress_request != '0) req_seen = 1'b1;
    if (bus.fifo_read) rd_cnt++;
    if (bus.to_egress_write) begin
      wr_cnt++;
      chk("write_with_pop", 64'(bus.fifo_read), 64'(1));
      if (exp_q.size() == 0) chk("unexpected_write", 64'(1), 64'(0));
      else chk("egress_data", 64'(bus.to_egress_data), 64'(exp_q.pop_front()));
    end
    @(posedge router_clk);
    #1;
    if (pop_pend && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_inputs();
  endtask

  task automatic clear_logs();
    req_log.delete(); wr_log.delete(); rd_log.delete(); busy_log.delete();
    wr_cnt = 0; rd_cnt = 0; req_seen = 1'b0;
  endtask

  task automatic push_pkt(input logic [3:0] mask, input logic [3:0] idx, input int n);
    logic [FLIT_WIDTH-1:0] f;
    logic [3:0]            dec;
    for (int i = 0; i < n; i++) begin
      f = '0;
      f[FLIT_WIDTH-1] = (i == n - 1);
      if (i == 0) f[31:0] = {24'($urandom), mask, idx};
      else        f[31:0] = $urandom;
      fifo_q.push_back(f);
      if (mask != 4'd0) begin
        if (i == 0) begin
          if (idx != 4'd0) begin
            dec = idx - 4'd1;
            exp_q.push_back({f[FLIT_WIDTH-1:4], dec});
          end
        end else begin
          exp_q.push_back(f);
        end
      end
    end
  endtask

  task automatic run_pkt();
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while ((fifo_q.size() != 0 || bus.busy) && k < 80);
    if (k >= 80) chk("packet_completion_timeout", 64'(1), 64'(0));
  endtask

  initial begin
    vec_cnt = 0; miss_cnt = 0;
    grant_allow = '1; ready_drv = '1;
    clear_logs();
    vecs[0] = '{4'b0100, 4'd2, 4, 4, 4, 1'b1};
    vecs[1] = '{4'b1011, 4'd3, 3, 3, 3, 1'b1};
    vecs[2] = '{4'b0001, 4'd0, 3, 2, 3, 1'b1};
    vecs[3] = '{4'b0000, 4'd1, 3, 0, 3, 1'b0};
    vecs[4] = '{4'b1111, 4'd1, 1, 1, 1, 1'b1};
    vecs[5] = '{4'b0010, 4'd0, 1, 0, 1, 1'b1};
    vecs[6] = '{4'b0000, 4'd0, 1, 0, 1, 1'b0};

    // Reset state, with a header waiting at the FIFO head.
    push_pkt(4'b0100, 4'd1, 2);
    drive_inputs();
    repeat (2) @(posedge router_clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_request", 64'(bus.to_egress_request), 64'(0));
    chk("rst_fifo_read", 64'(bus.fifo_read), 64'(0));
    chk("rst_write", 64'(bus.to_egress_write), 64'(0));
    chk("rst_data", 64'(bus.to_egress_data), 64'(0));
    fifo_q.delete(); exp_q.delete();
    drive_inputs();
    @(negedge router_clk) router_arst_n = 1'b1;
    @(posedge router_clk);
    #1;

    // Table-driven packets, all granted and ready.
    foreach (vecs[v]) begin
      clear_logs();
      push_pkt(vecs[v].mask, vecs[v].idx, vecs[v].nflits);
      run_pkt();
      chk($sformatf("v%0d_writes", v), 64'(wr_cnt), 64'(vecs[v].exp_writes));
      chk($sformatf("v%0d_pops", v), 64'(rd_cnt), 64'(vecs[v].exp_pops));
      chk($sformatf("v%0d_req_seen", v), 64'(req_seen), 64'(vecs[v].exp_req));
      chk($sformatf("v%0d_leftover", v), 64'(exp_q.size()), 64'(0));
      chk($sformatf("v%0d_req_idle", v), 64'(bus.to_egress_request), 64'(0));
      exp_q.delete();
    end

    // Unicast timing: header at c0, request c1, writes c2..c5, request low c6.
    clear_logs();
    push_pkt(4'b0100, 4'd2, 4);
    for (int c = 0; c < 8; c++) cycle();
    chk("uc_req_c0", 64'(req_log[0]), 64'(0));
    chk("uc_req_c1", 64'(req_log[1]), 64'(4'b0100));
    chk("uc_busy_c1", 64'(busy_log[1]), 64'(1));
    chk("uc_wr_c1", 64'(wr_log[1]), 64'(0));
    chk("uc_wr_c2", 64'(wr_log[2]), 64'(1));
    chk("uc_wr_c5", 64'(wr_log[5]), 64'(1));
    chk("uc_req_c5", 64'(req_log[5]), 64'(4'b0100));
    chk("uc_req_c6", 64'(req_log[6]), 64'(0));
    chk("uc_wr_c6", 64'(wr_log[6]), 64'(0));
    chk("uc_writes", 64'(wr_cnt), 64'(4));
    exp_q.delete();

    // Multicast 1011, egress 3 granted from c4, egress 1 not ready in c6,c7.
    clear_logs();
    push_pkt(4'b1011, 4'd1, 4);
    for (int c = 0; c < 13; c++) begin
      grant_allow = (c >= 4) ? 4'b1111 : 4'b0011;
      ready_drv   = (c == 6 || c == 7) ? 4'b1101 : 4'b1111;
      cycle();
    end
    grant_allow = '1; ready_drv = '1;
    for (int c = 1; c <= 4; c++) chk($sformatf("mc_no_pop_c%0d", c), 64'(rd_log[c]), 64'(0));
    chk("mc_pop_c5", 64'(rd_log[5]), 64'(1));
    chk("mc_wr_c5", 64'(wr_log[5]), 64'(1));
    chk("mc_stall_c6", 64'(wr_log[6]), 64'(0));
    chk("mc_stall_c7", 64'(wr_log[7]), 64'(0));
    chk("mc_wr_c8", 64'(wr_log[8]), 64'(1));
    chk("mc_wr_c10", 64'(wr_log[10]), 64'(1));
    chk("mc_wr_c11", 64'(wr_log[11]), 64'(0));
    chk("mc_writes", 64'(wr_cnt), 64'(4));
    chk("mc_leftover", 64'(exp_q.size()), 64'(0));
    exp_q.delete();

    // Asynchronous reset in the middle of a transfer.
    clear_logs();
    push_pkt(4'b0001, 4'd1, 6);
    for (int c = 0; c < 4; c++) cycle();
    chk("rx_pre_read", 64'(bus.fifo_read), 64'(1));
    #2 router_arst_n = 1'b0;
    #1;
    chk("rx_fifo_read", 64'(bus.fifo_read), 64'(0));
    chk("rx_write", 64'(bus.to_egress_write), 64'(0));
    chk("rx_request", 64'(bus.to_egress_request), 64'(0));
    chk("rx_busy", 64'(bus.busy), 64'(0));
    chk("rx_data", 64'(bus.to_egress_data), 64'(0));
    fifo_q.delete(); exp_q.delete();
    drive_inputs();
    @(negedge router_clk) router_arst_n = 1'b1;
    @(posedge router_clk);
    #1;
    clear_logs();
    push_pkt(4'b1000, 4'd0, 3);
    run_pkt();
    chk("rx_after_writes", 64'(wr_cnt), 64'(2));
    chk("rx_after_pops", 64'(rd_cnt), 64'(3));
    exp_q.delete();

`ifdef HYNOC_INGRESS_MCAST_TIMEOUT_EN
    // Partial grant: REQ c1..c8, RETRY c9 (requests 0), REQ again c10; full grant from c11.
    clear_logs();
    push_pkt(4'b0011, 4'd1, 2);
    for (int c = 0; c < 16; c++) begin
      grant_allow = (c >= 11) ? 4'b1111 : 4'b0001;
      cycle();
    end
    grant_allow = '1;
    chk("to_req_c1", 64'(req_log[1]), 64'(4'b0011));
    chk("to_req_c8", 64'(req_log[8]), 64'(4'b0011));
    chk("to_req_c9", 64'(req_log[9]), 64'(0));
    chk("to_req_c10", 64'(req_log[10]), 64'(4'b0011));
    chk("to_writes", 64'(wr_cnt), 64'(2));
    chk("to_idle", 64'(bus.busy), 64'(0));
    exp_q.delete();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
